// File: rtl/dma_sequencer.sv
// Command-driven multi-beat DMA sequencer between the core data memory port
// and the CGRA local buffer. Handles one STC/LFC/SCA command at a time and
// reports completion, errors and the active mode. All outputs are registered.
module dma_sequencer #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned CGRA_AW = 6,
  parameter int unsigned TO_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // command interface
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [9:0]         funct_i,
  input  logic [ADDR_W-1:0]  mem_base_i,
  input  logic [CGRA_AW-1:0] cgra_base_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [TO_W-1:0]    timeout_i,
  // data memory port
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic               mem_gnt_i,
  input  logic               mem_rvalid_i,
  input  logic [DATA_W-1:0]  mem_rdata_i,
  // CGRA local buffer and control
  output logic               cgra_we_o,
  output logic               cgra_re_o,
  output logic [CGRA_AW-1:0] cgra_addr_o,
  output logic [DATA_W-1:0]  cgra_wdata_o,
  input  logic [DATA_W-1:0]  cgra_rdata_i,
  output logic               cgra_start_o,
  input  logic               cgra_done_i,
  // status
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o,
  output logic [1:0]         dma_ctrl_o
);

  localparam int unsigned BeatBytes = DATA_W / 8;

  typedef enum logic [3:0] {
    StIdle, StMreq, StMwait, StCwr, StCrd, StCwait, StMwr, StStart, StRun, StDone
  } state_e;

  state_e state_q, state_d;

  // latched command and working registers
  logic [1:0]         mode_q, mode_d;
  logic [ADDR_W-1:0]  mem_base_q, mem_base_d;
  logic [CGRA_AW-1:0] cgra_base_q, cgra_base_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d, beat_inc;
  logic [TO_W-1:0]    timeout_q, timeout_d;
  logic [TO_W-1:0]    run_cnt_q, run_cnt_d, run_cnt_inc;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               err_flag_q, err_flag_d;

  // registered outputs
  logic               cmd_ready_q, cmd_ready_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               cgra_we_q, cgra_we_d;
  logic               cgra_re_q, cgra_re_d;
  logic [CGRA_AW-1:0] cgra_addr_q, cgra_addr_d;
  logic [DATA_W-1:0]  cgra_wdata_q, cgra_wdata_d;
  logic               cgra_start_q, cgra_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         dma_ctrl_q, dma_ctrl_d;

  logic accept, last_beat, timed_out;

  assign accept      = cmd_valid_i && cmd_ready_q;
  assign beat_inc    = beat_q + LEN_W'(1);
  assign last_beat   = (beat_inc == len_q);
  assign run_cnt_inc = run_cnt_q + TO_W'(1);
  // run_cnt_q counts completed RUN cycles; the limit hits at the end of the Nth one
  assign timed_out   = (timeout_q != '0) && (run_cnt_inc == timeout_q);

  // Next-state and working-register update
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mem_base_d  = mem_base_q;
    cgra_base_d = cgra_base_q;
    len_d       = len_q;
    beat_d      = beat_q;
    timeout_d   = timeout_q;
    run_cnt_d   = run_cnt_q;
    data_d      = data_q;
    err_flag_d  = err_flag_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          mem_base_d  = mem_base_i;
          cgra_base_d = cgra_base_i;
          len_d       = len_i;
          timeout_d   = timeout_i;
          beat_d      = '0;
          run_cnt_d   = '0;
          err_flag_d  = 1'b0;
          unique case (funct_i)
            10'd1: begin
              mode_d  = 2'b01;
              state_d = (len_i == '0) ? StDone : StMreq;
            end
            10'd2: begin
              mode_d  = 2'b10;
              state_d = (len_i == '0) ? StDone : StCrd;
            end
            10'd3: begin
              mode_d  = 2'b11;
              state_d = StStart;
            end
            default: begin
              mode_d     = 2'b00;
              err_flag_d = 1'b1;
              state_d    = StDone;
            end
          endcase
        end
      end
      StMreq: begin
        if (mem_gnt_i) state_d = StMwait;
      end
      StMwait: begin
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          state_d = StCwr;
        end
      end
      StCwr: begin
        if (last_beat) begin
          state_d = StDone;
        end else begin
          beat_d  = beat_inc;
          state_d = StMreq;
        end
      end
      StCrd: begin
        state_d = StCwait;
      end
      StCwait: begin
        data_d  = cgra_rdata_i;
        state_d = StMwr;
      end
      StMwr: begin
        if (mem_gnt_i) begin
          if (last_beat) begin
            state_d = StDone;
          end else begin
            beat_d  = beat_inc;
            state_d = StCrd;
          end
        end
      end
      StStart: begin
        // cgra_done_i is deliberately not looked at here
        run_cnt_d = '0;
        state_d   = StRun;
      end
      StRun: begin
        if (cgra_done_i) begin
          state_d = StDone;
        end else if (timed_out) begin
          err_flag_d = 1'b1;
          state_d    = StDone;
        end else begin
          run_cnt_d = run_cnt_inc;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    cmd_ready_d  = (state_d == StIdle);
    busy_d       = (state_d != StIdle);
    mem_req_d    = (state_d == StMreq) || (state_d == StMwr);
    mem_we_d     = (state_d == StMwr);
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    cgra_we_d    = (state_d == StCwr);
    cgra_re_d    = (state_d == StCrd);
    cgra_addr_d  = '0;
    cgra_wdata_d = '0;
    cgra_start_d = (state_d == StStart);
    done_d       = (state_d == StDone);
    err_d        = (state_d == StDone) && err_flag_d;
    dma_ctrl_d   = (state_d == StIdle) ? 2'b00 : mode_d;

    if (mem_req_d) begin
      mem_addr_d = mem_base_d + ADDR_W'(beat_d) * ADDR_W'(BeatBytes);
    end
    if (mem_we_d) begin
      mem_wdata_d = data_d;
    end
    if (cgra_we_d || cgra_re_d) begin
      cgra_addr_d = cgra_base_d + CGRA_AW'(beat_d);
    end
    if (cgra_we_d) begin
      cgra_wdata_d = data_d;
    end
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      mode_q       <= '0;
      mem_base_q   <= '0;
      cgra_base_q  <= '0;
      len_q        <= '0;
      beat_q       <= '0;
      timeout_q    <= '0;
      run_cnt_q    <= '0;
      data_q       <= '0;
      err_flag_q   <= 1'b0;
      cmd_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cgra_we_q    <= 1'b0;
      cgra_re_q    <= 1'b0;
      cgra_addr_q  <= '0;
      cgra_wdata_q <= '0;
      cgra_start_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      dma_ctrl_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      mem_base_q   <= mem_base_d;
      cgra_base_q  <= cgra_base_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
      timeout_q    <= timeout_d;
      run_cnt_q    <= run_cnt_d;
      data_q       <= data_d;
      err_flag_q   <= err_flag_d;
      cmd_ready_q  <= cmd_ready_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cgra_we_q    <= cgra_we_d;
      cgra_re_q    <= cgra_re_d;
      cgra_addr_q  <= cgra_addr_d;
      cgra_wdata_q <= cgra_wdata_d;
      cgra_start_q <= cgra_start_d;
      done_q       <= done_d;
      err_q        <= err_d;
      dma_ctrl_q   <= dma_ctrl_d;
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign busy_o       = busy_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign cgra_we_o    = cgra_we_q;
  assign cgra_re_o    = cgra_re_q;
  assign cgra_addr_o  = cgra_addr_q;
  assign cgra_wdata_o = cgra_wdata_q;
  assign cgra_start_o = cgra_start_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign dma_ctrl_o   = dma_ctrl_q;

endmodule

// File: tb/tb_dma_sequencer.sv
// Self-checking bench for dma_sequencer: directed plan cases plus random
// commands, checked against a transaction-level model of each command.
module tb_dma_sequencer;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned CGRA_AW = 6;
  localparam int unsigned TO_W    = 16;

  typedef logic [31:0] q32_t[$];

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               cmd_valid_i;
  logic               cmd_ready_o;
  logic [9:0]         funct_i;
  logic [ADDR_W-1:0]  mem_base_i;
  logic [CGRA_AW-1:0] cgra_base_i;
  logic [LEN_W-1:0]   len_i;
  logic [TO_W-1:0]    timeout_i;
  logic               mem_req_o, mem_we_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [DATA_W-1:0]  mem_wdata_o;
  logic               mem_gnt_i, mem_rvalid_i;
  logic [DATA_W-1:0]  mem_rdata_i;
  logic               cgra_we_o, cgra_re_o;
  logic [CGRA_AW-1:0] cgra_addr_o;
  logic [DATA_W-1:0]  cgra_wdata_o;
  logic [DATA_W-1:0]  cgra_rdata_i;
  logic               cgra_start_o;
  logic               cgra_done_i;
  logic               busy_o, done_o, err_o;
  logic [1:0]         dma_ctrl_o;

  dma_sequencer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .CGRA_AW(CGRA_AW),
    .TO_W   (TO_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .funct_i     (funct_i),
    .mem_base_i  (mem_base_i),
    .cgra_base_i (cgra_base_i),
    .len_i       (len_i),
    .timeout_i   (timeout_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .cgra_we_o   (cgra_we_o),
    .cgra_re_o   (cgra_re_o),
    .cgra_addr_o (cgra_addr_o),
    .cgra_wdata_o(cgra_wdata_o),
    .cgra_rdata_i(cgra_rdata_i),
    .cgra_start_o(cgra_start_o),
    .cgra_done_i (cgra_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .dma_ctrl_o  (dma_ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // CGRA buffer contents as seen by the bench
  logic [DATA_W-1:0] cgra_mem [64];

  // recorded transactions of the current command
  q32_t rd_addr_q, wr_addr_q, wr_data_q, cw_addr_q, cw_data_q, cr_addr_q;

  // memory contents are a fixed function of the byte address
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic any_out();
    return cmd_ready_o | mem_req_o | mem_we_o | (|mem_addr_o) | (|mem_wdata_o) | cgra_we_o |
           cgra_re_o | (|cgra_addr_o) | (|cgra_wdata_o) | cgra_start_o | busy_o | done_o |
           err_o | (|dma_ctrl_o);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input q32_t got, input q32_t exp);
    check({tag, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), 64'(got[i]), 64'(exp[i]));
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid_i  = 1'b0;
    funct_i      = '0;
    mem_base_i   = '0;
    cgra_base_i  = '0;
    len_i        = '0;
    timeout_i    = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    cgra_rdata_i = '0;
    cgra_done_i  = 1'b0;
  endtask

  // Issue one command, act as memory/CGRA responder, then compare with the model.
  // g: grant wait cycles, r: extra rvalid latency, d_cyc: cycle cgra_done_i is driven
  task automatic run_cmd(input string tag, input logic [9:0] f, input logic [31:0] mb,
                         input logic [5:0] cb, input logic [7:0] ln, input logic [15:0] to,
                         input int g, input int r, input int d_cyc, input bit stray_start);
    q32_t e_rd, e_wa, e_wd, e_cwa, e_cwd, e_cra;
    int   exp_done, exp_err, exp_start;
    logic [1:0] exp_mode;
    int   done_cyc = -1, done_cnt = 0, err_cnt = 0, start_cnt = 0;
    int   mode_bad = 0, ready_bad = 0, stab_bad = 0;
    int   gw = 0, rv_at = -1, limit;
    logic [31:0] rv_addr = '0, prev_addr = '0, prev_wd = '0;
    logic prev_we = 1'b0, waiting = 1'b0, cre_pend = 1'b0;
    logic [5:0] cre_addr = '0;
    logic [31:0] a;
    logic [5:0]  ca;

    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
    cw_addr_q.delete(); cw_data_q.delete(); cr_addr_q.delete();

    // model of the command
    exp_mode  = (f == 10'd1) ? 2'b01 : (f == 10'd2) ? 2'b10 : (f == 10'd3) ? 2'b11 : 2'b00;
    exp_err   = 0;
    exp_start = (f == 10'd3) ? 1 : 0;
    if (exp_mode == 2'b00) begin
      exp_done = 1;
      exp_err  = 1;
    end else if (f == 10'd3) begin
      if (to != 0 && d_cyc > 1 + int'(to)) begin
        exp_done = int'(to) + 2;
        exp_err  = 1;
      end else begin
        exp_done = d_cyc + 1;
      end
    end else if (ln == 0) begin
      exp_done = 1;
    end else begin
      for (int i = 0; i < int'(ln); i++) begin
        a  = mb + 32'(i * 4);
        ca = cb + 6'(i);
        if (f == 10'd1) begin
          e_rd.push_back(a);
          e_cwa.push_back(32'(ca));
          e_cwd.push_back(mem_val(a));
        end else begin
          e_cra.push_back(32'(ca));
          e_wa.push_back(a);
          e_wd.push_back(cgra_mem[ca]);
        end
      end
      exp_done = int'(ln) * ((f == 10'd1) ? (3 + g + r) : (3 + g)) + 1;
    end

    for (int i = 0; i < 20 && !cmd_ready_o; i++) step();
    check({tag, ":ready_before"}, 64'(cmd_ready_o), 64'd1);

    cmd_valid_i = 1'b1;
    funct_i     = f;
    mem_base_i  = mb;
    cgra_base_i = cb;
    len_i       = ln;
    timeout_i   = to;
    step();
    // junk on the command lines while busy must be ignored
    funct_i     = 10'($urandom);
    mem_base_i  = $urandom;
    cgra_base_i = 6'($urandom);
    len_i       = 8'($urandom);
    timeout_i   = 16'($urandom);

    limit = 30 + int'(ln) * (3 + g + r) + d_cyc + int'(to);
    for (int cyc = 1; cyc <= limit; cyc++) begin
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err_o) err_cnt++;
      if (cgra_start_o) start_cnt++;
      if (busy_o && dma_ctrl_o !== exp_mode) mode_bad++;
      if (busy_o && cmd_ready_o) ready_bad++;
      if (waiting && (mem_addr_o !== prev_addr || mem_we_o !== prev_we ||
                      mem_wdata_o !== prev_wd)) stab_bad++;

      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
      cgra_rdata_i = $urandom;
      cgra_done_i  = 1'b0;
      if (cre_pend) begin
        cgra_rdata_i = cgra_mem[cre_addr];
        cre_pend     = 1'b0;
      end
      if (cgra_re_o) begin
        cr_addr_q.push_back(32'(cgra_addr_o));
        cre_pend = 1'b1;
        cre_addr = cgra_addr_o;
      end
      if (cgra_we_o) begin
        cw_addr_q.push_back(32'(cgra_addr_o));
        cw_data_q.push_back(cgra_wdata_o);
        cgra_mem[cgra_addr_o] = cgra_wdata_o;
      end
      if (rv_at == cyc) begin
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = mem_val(rv_addr);
      end
      if (mem_req_o) begin
        if (gw == g) begin
          mem_gnt_i = 1'b1;
          gw        = 0;
          waiting   = 1'b0;
          if (mem_we_o) begin
            wr_addr_q.push_back(mem_addr_o);
            wr_data_q.push_back(mem_wdata_o);
          end else begin
            rd_addr_q.push_back(mem_addr_o);
            rv_at   = cyc + 1 + r;
            rv_addr = mem_addr_o;
          end
        end else begin
          gw++;
          waiting   = 1'b1;
          prev_addr = mem_addr_o;
          prev_we   = mem_we_o;
          prev_wd   = mem_wdata_o;
        end
      end else begin
        waiting = 1'b0;
      end
      if (cyc == d_cyc) cgra_done_i = 1'b1;
      if (stray_start && cgra_start_o) cgra_done_i = 1'b1;
      if (!busy_o) break;
      step();
    end
    idle_inputs();

    check({tag, ":done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, ":done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, ":err_pulses"}, 64'(err_cnt), 64'(exp_err));
    check({tag, ":start_pulses"}, 64'(start_cnt), 64'(exp_start));
    check({tag, ":mode_bad"}, 64'(mode_bad), 64'd0);
    check({tag, ":ready_while_busy"}, 64'(ready_bad), 64'd0);
    check({tag, ":req_unstable"}, 64'(stab_bad), 64'd0);
    check({tag, ":idle_after"}, {62'd0, busy_o, |dma_ctrl_o}, 64'd0);
    cmp_q({tag, ":mem_rd"}, rd_addr_q, e_rd);
    cmp_q({tag, ":mem_wa"}, wr_addr_q, e_wa);
    cmp_q({tag, ":mem_wd"}, wr_data_q, e_wd);
    cmp_q({tag, ":cgra_wa"}, cw_addr_q, e_cwa);
    cmp_q({tag, ":cgra_wd"}, cw_data_q, e_cwd);
    cmp_q({tag, ":cgra_ra"}, cr_addr_q, e_cra);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, g, r, d, ln, to;
    logic [9:0] f;

    for (int i = 0; i < 64; i++) cgra_mem[i] = $urandom;
    idle_inputs();
    rst_ni = 1'b0;
    #3;
    check("reset_outputs_zero", 64'(any_out()), 64'd0);
    step();
    step();
    rst_ni = 1'b1;
    check("ready_low_before_clock", 64'(cmd_ready_o), 64'd0);
    step();
    check("ready_after_first_clock", {62'd0, cmd_ready_o, busy_o}, 64'b10);

    // stray rvalid/done while idle
    mem_rvalid_i = 1'b1;
    cgra_done_i  = 1'b1;
    step();
    idle_inputs();
    check("stray_idle", {61'd0, busy_o, done_o, cmd_ready_o}, 64'b001);

    // directed plan cases
    run_cmd("stc_basic", 10'd1, 32'h0000_1000, 6'd4, 8'd3, 16'd0, 0, 0, 0, 1'b0);
    run_cmd("lfc_wrap", 10'd2, 32'h0000_2000, 6'd63, 8'd2, 16'd0, 2, 0, 0, 1'b0);
    run_cmd("sca_no_to", 10'd3, 32'h0, 6'd0, 8'd0, 16'd0, 0, 0, 11, 1'b1);
    run_cmd("sca_timeout", 10'd3, 32'h0, 6'd0, 8'd0, 16'd5, 0, 0, 20, 1'b0);
    run_cmd("illegal_funct", 10'h004, 32'h3000, 6'd1, 8'd3, 16'd0, 0, 0, 0, 1'b0);
    run_cmd("stc_len0", 10'd1, 32'h3000, 6'd1, 8'd0, 16'd0, 0, 0, 0, 1'b0);
    run_cmd("stc_addr_wrap", 10'd1, 32'hFFFF_FFF8, 6'd60, 8'd4, 16'd0, 1, 1, 0, 1'b0);

    // reset during MWAIT of the second beat
    check("pre_mid_ready", 64'(cmd_ready_o), 64'd1);
    cmd_valid_i = 1'b1;
    funct_i     = 10'd1;
    mem_base_i  = 32'h0000_4000;
    cgra_base_i = 6'd10;
    len_i       = 8'd3;
    step();                       // cycle 1: MREQ
    cmd_valid_i = 1'b0;
    mem_gnt_i   = 1'b1;
    step();                       // cycle 2: MWAIT
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = mem_val(32'h0000_4000);
    step();                       // cycle 3: CWR
    mem_rvalid_i = 1'b0;
    step();                       // cycle 4: MREQ
    mem_gnt_i = 1'b1;
    step();                       // cycle 5: MWAIT
    mem_gnt_i = 1'b0;
    check("mid_in_mwait", {61'd0, busy_o, mem_req_o, cgra_we_o}, 64'b100);
    #2;
    rst_ni = 1'b0;
    #1;
    check("mid_reset_zero", 64'(any_out()), 64'd0);
    step();
    check("mid_reset_held", 64'(any_out()), 64'd0);
    rst_ni = 1'b1;
    step();
    check("post_reset_idle", {61'd0, cmd_ready_o, busy_o, done_o}, 64'b100);
    run_cmd("stc_after_reset", 10'd1, 32'h0000_5000, 6'd20, 8'd2, 16'd0, 0, 0, 0, 1'b0);

    // random commands
    for (int n = 0; n < 14; n++) begin
      sel = int'($urandom_range(0, 5));
      g   = int'($urandom_range(0, 2));
      r   = int'($urandom_range(0, 2));
      ln  = int'($urandom_range(0, 5));
      to  = 0;
      d   = 0;
      if (sel <= 1) f = 10'd1;
      else if (sel <= 3) f = 10'd2;
      else if (sel == 4) f = 10'd3;
      else f = 10'(4 + $urandom_range(0, 1019));
      if (f == 10'd3) begin
        to = int'($urandom_range(0, 8));
        d  = int'($urandom_range(2, 14));
        if (to != 0 && d == to + 1) d = d + 1;
      end
      run_cmd($sformatf("rnd%0d", n), f, $urandom, 6'($urandom), 8'(ln), 16'(to),
              g, r, d, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_sequencer.md
# dma_sequencer

Parametrised multi-beat DMA engine between the core's data memory port and the CGRA local buffer. It replaces the single-cycle funct-to-DMACtrl decode with a command-driven sequencer. It accepts one custom-instruction command at a time (STC, LFC, SCA) and performs the burst, or the CGRA start/wait, autonomously. It reports completion, errors and the active mode back to the core pipeline.

## Interface
Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, data beat width; memory address stride per beat is DATA_W/8
- LEN_W, 8, beat-count width
- CGRA_AW, 6, CGRA local buffer word-address width
- TO_W, 16, SCA timeout counter width

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  high only in IDLE
- funct_i  in  10  command code: 1=STC (mem→CGRA), 2=LFC (CGRA→mem), 3=SCA (start CGRA and wait)
- mem_base_i  in  ADDR_W  memory start byte address
- cgra_base_i  in  CGRA_AW  CGRA start word address
- len_i  in  LEN_W  beat count; ignored for SCA
- timeout_i  in  TO_W  SCA cycle limit; 0 = no limit
- mem_req_o, mem_we_o  out  1  memory request / write enable
- mem_addr_o  out  ADDR_W  memory byte address
- mem_wdata_o  out  DATA_W  memory write data
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  DATA_W  read data
- cgra_we_o, cgra_re_o  out  1  CGRA buffer write / read strobe
- cgra_addr_o  out  CGRA_AW  CGRA buffer word address
- cgra_wdata_o  out  DATA_W  CGRA write data
- cgra_rdata_i  in  DATA_W  valid the cycle after cgra_re_o
- cgra_start_o  out  1  one-cycle compute start pulse
- cgra_done_i  in  1  CGRA compute finished
- busy_o  out  1  state != IDLE
- done_o, err_o  out  1  one-cycle completion / error pulses
- dma_ctrl_o  out  2  active mode: 01 STC, 10 LFC, 11 SCA, 00 idle

## Operation
- States: IDLE, MREQ, MWAIT, CWR, CRD, CWAIT, MWR, START, RUN, DONE.
- Command handshake: a command is accepted on cmd_valid_i & cmd_ready_o. funct_i, mem_base_i, cgra_base_i, len_i and timeout_i are latched. Beat counter is cleared.
- After acceptance, dma_ctrl_o holds the latched mode until DONE exits.
- Illegal funct (anything other than 1, 2 or 3): go to DONE with err_o set, no bus traffic.
- len_i = 0 for STC or LFC: go to DONE with no bus traffic and no error.
- STC path:
  - MREQ: mem_req_o=1, mem_we_o=0, mem_addr_o = base + beat*DATA_W/8. Held until mem_gnt_i, then go to MWAIT.
  - MWAIT: on mem_rvalid_i, latch mem_rdata_i and go to CWR.
  - CWR: cgra_we_o=1, cgra_addr_o = cgra_base + beat, cgra_wdata_o = latched data. Then go to DONE if last beat, else MREQ with beat+1.
- LFC path:
  - CRD: cgra_re_o=1, cgra_addr_o = cgra_base + beat. Then go to CWAIT.
  - CWAIT: capture cgra_rdata_i, then go to MWR.
  - MWR: mem_req_o=1, mem_we_o=1, mem_wdata_o = captured data. Held until mem_gnt_i. Then go to DONE if last beat, else CRD.
- SCA path:
  - START: cgra_start_o=1, then go to RUN.
  - RUN: wait for cgra_done_i. If timeout_i != 0 and the cycle count in RUN reaches timeout_i, go to DONE with err_o.
- DONE: done_o=1 for one cycle (err_o too if flagged), then go to IDLE.
- Address arithmetic: memory addresses wrap modulo 2^ADDR_W; CGRA addresses wrap modulo 2^CGRA_AW.
- Stray inputs: mem_rvalid_i outside MWAIT and cgra_done_i outside RUN are ignored. cgra_done_i in the START cycle is ignored.
- Request stability: while mem_req_o is high without mem_gnt_i, mem_addr_o, mem_we_o and mem_wdata_o stay stable.

## Timing
- Reset: all outputs 0, state IDLE, counters 0. cmd_ready_o rises on the first clock after rst_ni deasserts.
- Reset mid-operation: the in-flight request is abandoned, with no done_o or err_o pulse.
- All outputs are registered or decoded from state registers. No combinational path from any *_i to any *_o except through state.
- STC/LFC with zero-wait grant and next-cycle rvalid: 3 cycles per beat. Accept at cycle 0; done_o at cycle 3N+1.
- SCA: cgra_start_o at cycle 1. done_o one cycle after cgra_done_i is sampled in RUN.
- Illegal funct or len=0: done_o at cycle 1; cmd_ready_o high again at cycle 2.
- Back-to-back commands: the next command is accepted at the earliest in the cycle after done_o.

## Test plan
- STC, base 0x1000, cgra_base 4, len 3, gnt immediate, rvalid 1 cycle later → reads at 0x1000/0x1004/0x1008; CGRA writes to addresses 4/5/6 with matching data; done_o at cycle 10; dma_ctrl_o=01 throughout.
- LFC, len 2, cgra_base 63 (CGRA_AW=6), gnt delayed 2 cycles per beat → CGRA reads at 63 then 0 (wrap); mem writes carry those data; addr and wdata stable while waiting for gnt; done_o asserted.
- SCA with cgra_done_i after 10 cycles, timeout 0 → single cgra_start_o pulse; done_o one cycle after done; err_o=0. Repeat with timeout 5 → done_o and err_o both pulse after 5 RUN cycles.
- funct=0x004 and len=0 STC → done_o at cycle 1; err_o=1 only for the illegal funct; no mem_req_o or cgra strobes.
- rst_ni pulled low during MWAIT of beat 2 → all outputs 0 immediately; no done_o; a new STC after reset completes normally.
- Stray mem_rvalid_i in IDLE and cgra_done_i in START → ignored, no state change.
